// File: rtl/accum_pkg.sv
// Shared constants and FSM state type for the accumulator readout block.
package accum_pkg;

  localparam int NUM_OF_ROM_DEF = 32;
  localparam int ACC_W          = 24;
  localparam int IN_W           = 17;
  localparam int Q              = 3329;

  // Barrett constant floor(2^36 / Q): for 24-bit inputs the quotient estimate
  // is never more than one below the exact quotient.
  localparam int          BARRETT_K = 36;
  localparam logic [24:0] BARRETT_M = 25'd20642678;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SNAP,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/accum_mod_reduce.sv
// Combinational 24-bit Barrett reduction modulo Q; the result is always below Q.
module accum_mod_reduce
  import accum_pkg::*;
(
  input  logic [ACC_W-1:0] x,
  output logic [ACC_W-1:0] r
);

  logic [48:0]      prod;
  logic [12:0]      q_est;
  logic [ACC_W-1:0] rem;

  // NOTE: every variable is assigned on every path here, so no latch can be inferred.
  always_comb begin
    prod  = {25'd0, x} * {24'd0, BARRETT_M};
    q_est = 13'(prod >> BARRETT_K);
    // The estimate is at most one short, so one conditional subtract finishes the job.
    rem   = x - (ACC_W'(q_est) * ACC_W'(Q));
    r     = (rem >= ACC_W'(Q)) ? rem - ACC_W'(Q) : rem;
  end

endmodule

// File: rtl/accum_readout.sv
// Accumulator readout: counts accumulation beats, snapshots all lanes, drains them one per transfer.
// Optional macro ACCUM_READOUT_MODRED_EN reduces each drained word modulo Q.
module accum_readout
  import accum_pkg::*;
#(
  parameter  int NUM_OF_ROM = NUM_OF_ROM_DEF,
  parameter  int LEN_W      = 8,
  localparam int IDX_W      = (NUM_OF_ROM > 1) ? $clog2(NUM_OF_ROM) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start_i,
  input  logic [LEN_W-1:0]            len_i,
  input  logic                        accum_valid_i,
  output logic                        accum_en_o,
  input  logic [ACC_W*NUM_OF_ROM-1:0] result_i,
  output logic [ACC_W-1:0]            dout_o,
  output logic [IDX_W-1:0]            dout_idx_o,
  output logic                        dout_last_o,
  output logic                        dout_valid_o,
  input  logic                        dout_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   beat_cnt;
  logic [LEN_W:0]   beat_target;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] buffer [NUM_OF_ROM];
  logic             done_q;
  logic             final_beat;
  logic             xfer;
  logic             last_lane;
  logic [ACC_W-1:0] lane_word;
  logic [ACC_W-1:0] lane_out;

  // A latched length of zero stands for the full 2^LEN_W beats.
  assign beat_target = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
  assign final_beat  = (state == ST_ACCUM) && accum_valid_i &&
                       ((beat_cnt + {{LEN_W{1'b0}}, 1'b1}) == beat_target);
  assign last_lane   = (idx == IDX_W'(NUM_OF_ROM - 1));
  assign xfer        = (state == ST_DRAIN) && dout_ready_i;
  assign lane_word   = buffer[idx];

`ifdef ACCUM_READOUT_MODRED_EN
  accum_mod_reduce u_mod_reduce (
    .x (lane_word),
    .r (lane_out)
  );
`else
  assign lane_out = lane_word;
`endif

  // NOTE: state-holding blocks use non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accum_en_o   = 1'b0;
    dout_valid_o = 1'b0;
    dout_o       = '0;
    dout_idx_o   = '0;
    dout_last_o  = 1'b0;
    busy_o       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start_i) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        accum_en_o = accum_valid_i;
        if (final_beat) state_nxt = ST_SNAP;
      end
      ST_SNAP: begin
        state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        dout_valid_o = 1'b1;
        dout_o       = lane_out;
        dout_idx_o   = idx;
        dout_last_o  = last_lane;
        if (xfer && last_lane) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q    <= '0;
      beat_cnt <= '0;
      idx      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= xfer && last_lane;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            len_q    <= len_i;
            beat_cnt <= '0;
          end
        end
        ST_ACCUM: begin
          if (accum_valid_i) beat_cnt <= beat_cnt + {{LEN_W{1'b0}}, 1'b1};
        end
        ST_SNAP: begin
          idx <= '0;
        end
        ST_DRAIN: begin
          if (xfer) idx <= last_lane ? '0 : idx + IDX_W'(1);
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

  // NOTE: the snapshot buffer is cleared by reset like any other register so
  // that no stale frame data can ever appear on dout_o.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OF_ROM; i++) buffer[i] <= '0;
    end else if (state == ST_SNAP) begin
      for (int i = 0; i < NUM_OF_ROM; i++) buffer[i] <= result_i[i*ACC_W +: ACC_W];
    end
  end

  assign done_o = done_q;

endmodule
